mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single line-wide memory port between the instruction cache and the data cache. It sits between both cache miss/write-back interfaces and main memory. It latches one request at a time, drives it to memory, and routes the memory's `ready` pulse and line data back to the granted cache. Arbitration is round-robin, or fixed data-cache priority when configured.

## Interface
Parameters:
- `CACHE_LINE_SIZE`, default 128: line width in bits for memory and cache data buses.
- `DCACHE_PRIORITY`, default 0: 0 selects round-robin; 1 makes the dcache always win a tie.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_icache_read_en`  in  1  icache line-fill request, level, held until its ready.
- `in_icache_addr`  in  32  icache request address.
- `out_icache_read_data`  out  CACHE_LINE_SIZE  fill data to icache.
- `out_icache_ready`  out  1  one-cycle completion pulse to icache.
- `in_dcache_read_en`  in  1  dcache fill request, level.
- `in_dcache_write_en`  in  1  dcache write-back request, level; wins over `in_dcache_read_en` if both are high.
- `in_dcache_addr`  in  32  dcache request address.
- `in_dcache_write_data`  in  CACHE_LINE_SIZE  write-back line.
- `out_dcache_read_data`  out  CACHE_LINE_SIZE  fill data to dcache.
- `out_dcache_ready`  out  1  one-cycle completion pulse to dcache.
- `out_mem_read_en`  out  1  memory read request, registered.
- `out_mem_write_en`  out  1  memory write request, registered.
- `out_mem_addr`  out  32  line-aligned address, bits [3:0] = 0, registered.
- `out_mem_write_data`  out  CACHE_LINE_SIZE  registered write line.
- `in_mem_read_data`  in  CACHE_LINE_SIZE  memory read line, valid with `in_mem_ready`.
- `in_mem_ready`  in  1  memory completion pulse.
- `out_grant`  out  2  one-hot owner: bit0 = icache, bit1 = dcache; 00 when none.
- `out_busy`  out  1  high in BUSY or RELEASE.
- `out_icache_count`, `out_dcache_count`  out  32  completed transactions per requester; wrap modulo 2^32.

## Operation
State machine: IDLE, BUSY, RELEASE.

- **IDLE**
  - Sample the requests. If none is pending, stay in IDLE.
  - If exactly one requester is pending, grant it.
  - If both are pending:
    - `DCACHE_PRIORITY=1`: grant the dcache.
    - Otherwise: grant the requester not granted last. The last-grant pointer resets to icache, so the first tie goes to the dcache.
  - On grant:
    - Latch the op (dcache write > dcache read > icache read), the address with [3:0] cleared, and the write data.
    - Set the matching `out_mem_*_en` and `out_grant`. Go to BUSY.
- **BUSY**
  - Memory outputs hold the latched values. Requester address or data changes are ignored.
  - Ready routing is combinational: granted `out_*_ready = in_mem_ready`, and granted `out_*_read_data = in_mem_read_data`. The non-granted ready output is 0 and its data output is 0.
  - On the edge where `in_mem_ready` is sampled high:
    - Clear both memory enables.
    - Increment the granted counter.
    - Update the last-grant pointer.
    - Go to RELEASE. `out_grant` stays set through RELEASE.
- **RELEASE**
  - Exactly one cycle; no requests are sampled. This absorbs the requester's registered drop of its enable after ready.
  - Next state is IDLE, with `out_grant` = 00.
- `in_mem_ready` is ignored in IDLE and RELEASE; no ready pulse is produced there.
- Write-back followed by fill from the same dcache is two separate transactions. The icache may be granted between them in round-robin mode.

## Timing
- Reset values:
  - state = IDLE
  - all `out_mem_*` = 0
  - `out_grant` = 00, `out_busy` = 0
  - both ready outputs = 0, both read_data outputs = 0
  - both counters = 0
  - last-grant pointer = icache
- Reset in any state (including BUSY mid-transaction) aborts the transaction: no ready pulse, no count increment, next cycle IDLE.
- Request sampled at edge T: memory enable is high from cycle T+1.
- Earliest requester ready is in cycle T+1, if memory returns `in_mem_ready` the same cycle.
- Memory enables drop on the edge after the ready cycle.
- Back-to-back transactions have a minimum of 2 cycles with enables low (RELEASE, IDLE).
- A requester that drops its request while in BUSY does not cancel the transaction; it completes and counts.
- A request raised in the same cycle as another's completion is first sampled in the IDLE following RELEASE.

## Test plan
- Single icache read of addr 0x0000_1234, memory ready 3 cycles after enable, data 0xA5..A5 → `out_mem_addr` = 0x0000_1230, `out_mem_read_en` high 3 cycles, one `out_icache_ready` pulse with data 0xA5..A5, `out_icache_count` = 1, `out_dcache_ready` never high.
- Both caches read in the same cycle, `DCACHE_PRIORITY=0`, with requests held → grant order dcache, icache, dcache, icache. Each grant is separated by 2 enable-low cycles.
- Same as above with `DCACHE_PRIORITY=1` and the dcache re-requesting continuously → the icache is never granted while the dcache requests; the icache is granted the first IDLE after the dcache drops.
- Dcache with write_en and read_en both high, addr 0x8000_0010, wdata 0x1122..FF → `out_mem_write_en`=1, `out_mem_read_en`=0, `out_mem_write_data` = 0x1122..FF.
- Change `in_dcache_addr` to 0xDEAD_0000 during BUSY → `out_mem_addr` stays at the latched value until completion.
- Assert `reset` in BUSY one cycle before `in_mem_ready` → next cycle all enables 0, no ready pulse, counters 0; after reset a pending request is re-granted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one line-wide memory port between the icache and the
// dcache. One request is latched at a time and driven to memory. The memory
// ready pulse and the read line are routed back to whichever cache owns the
// grant.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   in_icache_*                     icache fill request (level) + address
//   out_icache_read_data/_ready     icache fill data + completion pulse
//   in_dcache_*                     dcache fill / write-back request + addr + line
//   out_dcache_read_data/_ready     dcache fill data + completion pulse
//   out_mem_*                       registered memory request (addr [3:0] = 0)
//   in_mem_read_data/_ready         memory read line + completion pulse
//   out_grant                       one-hot owner {dcache, icache}
//   out_busy                        transaction in flight or releasing
//   out_icache_count/_dcache_count  completed transactions per requester
module mem_arbiter #(
  parameter int CACHE_LINE_SIZE = 128,
  parameter int DCACHE_PRIORITY = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_icache_read_en,
  input  logic [31:0]                in_icache_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_icache_read_data,
  output logic                       out_icache_ready,
  input  logic                       in_dcache_read_en,
  input  logic                       in_dcache_write_en,
  input  logic [31:0]                in_dcache_addr,
  input  logic [CACHE_LINE_SIZE-1:0] in_dcache_write_data,
  output logic [CACHE_LINE_SIZE-1:0] out_dcache_read_data,
  output logic                       out_dcache_ready,
  output logic                       out_mem_read_en,
  output logic                       out_mem_write_en,
  output logic [31:0]                out_mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] out_mem_write_data,
  input  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data,
  input  logic                       in_mem_ready,
  output logic [1:0]                 out_grant,
  output logic                       out_busy,
  output logic [31:0]                out_icache_count,
  output logic [31:0]                out_dcache_count
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_REL} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 grant_q, grant_d;
  logic                       rd_q, rd_d, wr_q, wr_d;
  logic [31:0]                addr_q, addr_d;
  logic [CACHE_LINE_SIZE-1:0] wdata_q, wdata_d;
  logic                       last_dc_q, last_dc_d;  // 1: last completed owner was dcache
  logic [31:0]                icnt_q, icnt_d, dcnt_q, dcnt_d;

  logic ireq, dreq, pick_d;

  assign ireq = in_icache_read_en;
  assign dreq = in_dcache_read_en | in_dcache_write_en;
  // dcache wins when alone, when it has fixed priority, or when icache went last.
  assign pick_d = dreq & (~ireq | (DCACHE_PRIORITY != 0) | ~last_dc_q);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    last_dc_d = last_dc_q;
    icnt_d    = icnt_q;
    dcnt_d    = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (ireq | dreq) begin
          state_d = S_BUSY;
          if (pick_d) begin
            grant_d = 2'b10;
            wr_d    = in_dcache_write_en;
            rd_d    = ~in_dcache_write_en;
            addr_d  = {in_dcache_addr[31:4], 4'h0};
            wdata_d = in_dcache_write_data;
          end else begin
            grant_d = 2'b01;
            wr_d    = 1'b0;
            rd_d    = 1'b1;
            addr_d  = {in_icache_addr[31:4], 4'h0};
          end
        end
      end
      S_BUSY: begin
        if (in_mem_ready) begin
          state_d   = S_REL;
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          last_dc_d = grant_q[1];
          if (grant_q[0]) icnt_d = icnt_q + 32'd1;
          if (grant_q[1]) dcnt_d = dcnt_q + 32'd1;
        end
      end
      S_REL: begin
        // Requests are not sampled here: the owner is still dropping its enable.
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 2'b00;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_dc_q <= 1'b0;
      icnt_q    <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_dc_q <= last_dc_d;
      icnt_q    <= icnt_d;
      dcnt_q    <= dcnt_d;
    end
  end

  // Return path is combinational so the owner sees ready in the memory's ready cycle.
  logic busy_s;
  assign busy_s = (state_q == S_BUSY);

  assign out_icache_ready     = busy_s & grant_q[0] & in_mem_ready;
  assign out_dcache_ready     = busy_s & grant_q[1] & in_mem_ready;
  assign out_icache_read_data = (busy_s & grant_q[0]) ? in_mem_read_data : '0;
  assign out_dcache_read_data = (busy_s & grant_q[1]) ? in_mem_read_data : '0;

  assign out_mem_read_en    = rd_q;
  assign out_mem_write_en   = wr_q;
  assign out_mem_addr       = addr_q;
  assign out_mem_write_data = wdata_q;
  assign out_grant          = grant_q;
  assign out_busy           = (state_q != S_IDLE);
  assign out_icache_count   = icnt_q;
  assign out_dcache_count   = dcnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int L = 128;
  localparam logic [L-1:0] A5 = {16{8'hA5}};
  localparam logic [L-1:0] WD = 128'h11223344_55667788_99AABBCC_DDEEFF00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ir, dr, dw;
  logic [31:0]   iaddr, daddr;
  logic [L-1:0]  dwd;
  logic          mr [2];
  logic [L-1:0]  md [2];

  logic          o_rd [2], o_wr [2], o_busy [2], o_ir [2], o_dr [2];
  logic [1:0]    o_gnt [2];
  logic [31:0]   o_addr [2], o_ci [2], o_cd [2];
  logic [L-1:0]  o_wd [2], o_id [2], o_dd [2];

  // Instance 0: round-robin, instance 1: fixed dcache priority. Requests shared,
  // each has its own memory side.
  mem_arbiter #(.CACHE_LINE_SIZE(L), .DCACHE_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .in_icache_read_en(ir), .in_icache_addr(iaddr),
    .out_icache_read_data(o_id[0]), .out_icache_ready(o_ir[0]),
    .in_dcache_read_en(dr), .in_dcache_write_en(dw), .in_dcache_addr(daddr),
    .in_dcache_write_data(dwd),
    .out_dcache_read_data(o_dd[0]), .out_dcache_ready(o_dr[0]),
    .out_mem_read_en(o_rd[0]), .out_mem_write_en(o_wr[0]), .out_mem_addr(o_addr[0]),
    .out_mem_write_data(o_wd[0]), .in_mem_read_data(md[0]), .in_mem_ready(mr[0]),
    .out_grant(o_gnt[0]), .out_busy(o_busy[0]),
    .out_icache_count(o_ci[0]), .out_dcache_count(o_cd[0]));

  mem_arbiter #(.CACHE_LINE_SIZE(L), .DCACHE_PRIORITY(1)) u_pr (
    .clk(clk), .reset(reset),
    .in_icache_read_en(ir), .in_icache_addr(iaddr),
    .out_icache_read_data(o_id[1]), .out_icache_ready(o_ir[1]),
    .in_dcache_read_en(dr), .in_dcache_write_en(dw), .in_dcache_addr(daddr),
    .in_dcache_write_data(dwd),
    .out_dcache_read_data(o_dd[1]), .out_dcache_ready(o_dr[1]),
    .out_mem_read_en(o_rd[1]), .out_mem_write_en(o_wr[1]), .out_mem_addr(o_addr[1]),
    .out_mem_write_data(o_wd[1]), .in_mem_read_data(md[1]), .in_mem_ready(mr[1]),
    .out_grant(o_gnt[1]), .out_busy(o_busy[1]),
    .out_icache_count(o_ci[1]), .out_dcache_count(o_cd[1]));

  int nchk = 0, nerr = 0;

  task automatic check(input string nm, input logic [511:0] a, input logic [511:0] e);
    nchk++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask

  // Transaction-level reference: who owns the port, which phase of the
  // transaction it is in (0 none, 1 in flight, 2 release), and what was latched.
  typedef struct {
    int          phase;
    int          owner;   // 0 none, 1 icache, 2 dcache
    int          last;    // last completed owner
    bit          rd, wr;
    logic [31:0] addr;
    logic [L-1:0] wd;
    logic [31:0] ci, cd;
  } model_t;
  model_t m [2];

  task automatic step_models();
    int who;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m[k].phase = 0; m[k].owner = 0; m[k].last = 1;
        m[k].rd = 0; m[k].wr = 0; m[k].addr = '0; m[k].wd = '0;
        m[k].ci = 0; m[k].cd = 0;
      end else if (m[k].phase == 0) begin
        who = 0;
        if (ir && (dr || dw)) who = (k == 1 || m[k].last == 1) ? 2 : 1;
        else if (ir)          who = 1;
        else if (dr || dw)    who = 2;
        if (who == 1) begin
          m[k].owner = 1; m[k].phase = 1; m[k].rd = 1; m[k].wr = 0;
          m[k].addr = iaddr & 32'hFFFF_FFF0;
        end else if (who == 2) begin
          m[k].owner = 2; m[k].phase = 1; m[k].wr = dw; m[k].rd = !dw;
          m[k].addr = daddr & 32'hFFFF_FFF0; m[k].wd = dwd;
        end
      end else if (m[k].phase == 1) begin
        if (mr[k]) begin
          m[k].rd = 0; m[k].wr = 0;
          if (m[k].owner == 1) m[k].ci = m[k].ci + 1;
          else                 m[k].cd = m[k].cd + 1;
          m[k].last = m[k].owner; m[k].phase = 2;
        end
      end else begin
        m[k].phase = 0; m[k].owner = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    step_models();
  endtask

  task automatic chk();
    logic [511:0] e, a;
    logic [1:0] g;
    bit en, fl_i, fl_d;
    #1;
    for (int k = 0; k < 2; k++) begin
      g    = (m[k].owner == 1) ? 2'b01 : (m[k].owner == 2) ? 2'b10 : 2'b00;
      en   = m[k].rd | m[k].wr;
      fl_i = (m[k].phase == 1) && (m[k].owner == 1);
      fl_d = (m[k].phase == 1) && (m[k].owner == 2);
      e = {m[k].rd, m[k].wr, g, 1'(m[k].phase != 0), 1'(fl_i && mr[k]), 1'(fl_d && mr[k]),
           fl_i ? md[k] : {L{1'b0}}, fl_d ? md[k] : {L{1'b0}}, m[k].ci, m[k].cd,
           en ? m[k].addr : 32'h0, m[k].wr ? m[k].wd : {L{1'b0}}};
      a = {o_rd[k], o_wr[k], o_gnt[k], o_busy[k], o_ir[k], o_dr[k], o_id[k], o_dd[k],
           o_ci[k], o_cd[k], en ? o_addr[k] : 32'h0, m[k].wr ? o_wd[k] : {L{1'b0}}};
      check($sformatf("model_dut%0d", k), a, e);
    end
  endtask

  typedef struct {
    bit ir, dr, dw, mr;
    logic [31:0] ia, da;
    bit e_rd, e_wr; logic [1:0] e_g; bit e_busy, e_ir, e_dr;
    logic [31:0] e_addr, e_ci, e_cd;
    bit e_ion, e_don;
  } vec_t;
  vec_t tv [11];

  int gq0 [$], gq1 [$];
  bit prev0, prev1;
  int gap0;
  bit seen;

  initial begin
    // ir dr dw mr ia da | rd wr g busy irdy drdy addr ci cd ion don
    tv[0]  = '{1,0,0,0, 32'h1234, 32'h0,         0,0,2'b00,0,0,0, 32'h0,         0,0, 0,0};
    tv[1]  = '{1,0,0,0, 32'h1234, 32'h0,         1,0,2'b01,1,0,0, 32'h1230,      0,0, 1,0};
    tv[2]  = '{1,0,0,0, 32'h1234, 32'h0,         1,0,2'b01,1,0,0, 32'h1230,      0,0, 1,0};
    tv[3]  = '{1,0,0,1, 32'h1234, 32'h0,         1,0,2'b01,1,1,0, 32'h1230,      0,0, 1,0};
    tv[4]  = '{1,0,0,1, 32'h1234, 32'h0,         0,0,2'b01,1,0,0, 32'h0,         1,0, 0,0};
    tv[5]  = '{0,0,0,1, 32'h1234, 32'h0,         0,0,2'b00,0,0,0, 32'h0,         1,0, 0,0};
    tv[6]  = '{0,1,1,0, 32'h0,    32'h8000_0010, 0,0,2'b00,0,0,0, 32'h0,         1,0, 0,0};
    tv[7]  = '{0,1,1,0, 32'h0,    32'hDEAD_0000, 0,1,2'b10,1,0,0, 32'h8000_0010, 1,0, 0,1};
    tv[8]  = '{0,1,1,1, 32'h0,    32'hDEAD_0000, 0,1,2'b10,1,0,1, 32'h8000_0010, 1,0, 0,1};
    tv[9]  = '{0,0,0,0, 32'h0,    32'h0,         0,0,2'b10,1,0,0, 32'h0,         1,1, 0,0};
    tv[10] = '{0,0,0,0, 32'h0,    32'h0,         0,0,2'b00,0,0,0, 32'h0,         1,1, 0,0};

    reset = 1; ir = 0; dr = 0; dw = 0; iaddr = 0; daddr = 0; dwd = WD;
    for (int k = 0; k < 2; k++) begin mr[k] = 0; md[k] = A5; end

    // reset state
    tick(); chk();
    tick(); chk();
    check("rst_mem", {o_rd[0], o_wr[0], o_addr[0], o_wd[0], o_gnt[0], o_busy[0]}, '0);
    reset = 0;

    // directed vectors on the round-robin instance
    for (int r = 0; r < 11; r++) begin
      tick();
      ir = tv[r].ir; dr = tv[r].dr; dw = tv[r].dw; iaddr = tv[r].ia; daddr = tv[r].da;
      mr[0] = tv[r].mr; mr[1] = tv[r].mr;
      chk();
      check($sformatf("vec%0d", r),
        {o_rd[0], o_wr[0], o_gnt[0], o_busy[0], o_ir[0], o_dr[0],
         (o_rd[0] | o_wr[0]) ? o_addr[0] : 32'h0, o_wr[0] ? o_wd[0] : {L{1'b0}},
         o_id[0], o_dd[0], o_ci[0], o_cd[0]},
        {tv[r].e_rd, tv[r].e_wr, tv[r].e_g, tv[r].e_busy, tv[r].e_ir, tv[r].e_dr,
         tv[r].e_addr, tv[r].e_wr ? WD : {L{1'b0}},
         tv[r].e_ion ? A5 : {L{1'b0}}, tv[r].e_don ? A5 : {L{1'b0}}, tv[r].e_ci, tv[r].e_cd});
    end

    // reset mid-transaction aborts it; pending request is re-granted
    tick(); ir = 1; chk();
    tick(); chk();
    check("busy_before_rst", {o_busy[0], o_rd[0]}, 2'b11);
    tick(); reset = 1; chk();
    tick(); reset = 0; mr[0] = 1; mr[1] = 1; chk();
    check("rst_abort", {o_rd[0], o_busy[0], o_ir[0], o_ci[0], o_cd[0]}, '0);
    tick(); chk();
    check("regrant", {o_rd[0], o_gnt[0], o_ir[0]}, {1'b1, 2'b01, 1'b1});
    tick(); ir = 0; mr[0] = 0; mr[1] = 0; chk();
    check("regrant_cnt", o_ci[0], 32'd1);

    // tie arbitration with immediate memory ready
    tick(); ir = 1; dr = 1; mr[0] = 1; mr[1] = 1; chk();
    prev0 = o_rd[0] | o_wr[0]; prev1 = o_rd[1] | o_wr[1]; gap0 = -1;
    for (int c = 0; c < 13; c++) begin
      tick(); chk();
      if ((o_rd[0] | o_wr[0]) && !prev0) begin
        gq0.push_back(int'(o_gnt[0]));
        if (gap0 >= 0) check("rr_gap", gap0, 2);
        gap0 = 0;
      end else if (!(o_rd[0] | o_wr[0]) && gap0 >= 0) gap0++;
      if ((o_rd[1] | o_wr[1]) && !prev1) gq1.push_back(int'(o_gnt[1]));
      prev0 = o_rd[0] | o_wr[0]; prev1 = o_rd[1] | o_wr[1];
    end
    check("rr_ngrants", 32'(gq0.size() >= 4), 1);
    if (gq0.size() >= 4) check("rr_order", {gq0[0], gq0[1], gq0[2], gq0[3]}, {32'd2, 32'd1, 32'd2, 32'd1});
    check("pr_ngrants", 32'(gq1.size() >= 4), 1);
    if (gq1.size() >= 4) check("pr_order", {gq1[0], gq1[1], gq1[2], gq1[3]}, {32'd2, 32'd2, 32'd2, 32'd2});

    // dcache drops: the priority instance must hand over to the icache next
    tick(); dr = 0; chk();
    seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      prev1 = o_rd[1] | o_wr[1];
      tick(); chk();
      if ((o_rd[1] | o_wr[1]) && !prev1) begin
        seen = 1;
        check("pr_handover", o_gnt[1], 2'b01);
      end
    end
    check("pr_handover_seen", 32'(seen), 1);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) ir = ~ir;
      if ($urandom_range(0, 3) == 0) dr = ~dr;
      if ($urandom_range(0, 5) == 0) dw = ~dw;
      iaddr = $urandom; daddr = $urandom;
      dwd = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < 2; k++) begin
        mr[k] = ($urandom_range(0, 2) == 0);
        md[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      chk();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
